// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU divider.
// Build option: ALU_DIV_SIGNED_EN enables signed division in alu_divider_seq.
package alu_pkg;

  localparam int unsigned ALU_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

  // Step counter must be able to hold the value W.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  localparam int unsigned ALU_CNT_W = cnt_width(ALU_W);

endpackage

// File: rtl/alu_divider_seq_fullsubtractor.sv
// One-bit full subtractor; chained to form the divider's trial subtractor.
module fullsubtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bw_i,
  output logic d_o,
  output logic bw_o
);

  assign d_o  = a_i ^ b_i ^ bw_i;
  assign bw_o = (~a_i & b_i) | (~(a_i ^ b_i) & bw_i);

endmodule

// File: rtl/alu_divider_seq.sv
// Multi-cycle restoring divider, one shift-and-subtract step per clock.
// Build option: define ALU_DIV_SIGNED_EN for signed operation (adds a FIX state).
module alu_divider_seq
  import alu_pkg::*;
#(
  parameter int unsigned W = ALU_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  input  logic         signed_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] quotient_o,
  output logic [W-1:0] remainder_o,
  output logic         dz_o
);

  localparam int unsigned CW = cnt_width(W);
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  div_state_e   state_q;
  logic [W-1:0] q_q, r_q, dvs_q;
  logic [CW-1:0] cnt_q;
  logic         busy_q, done_q, dz_q;
  logic [W-1:0] quo_q, rem_q;

  logic [W:0]   trial_a, trial_b, trial_d;
  logic [W+1:0] bw;
  logic         borrow;
  logic [W-1:0] q_d, r_d;
  logic         sgn_in;
  logic [W-1:0] dvd_mag, dvs_mag;
  logic         unused_dmsb;

`ifdef ALU_DIV_SIGNED_EN
  logic sgn_q, neg_quo_q, neg_rem_q;
  assign sgn_in = signed_i;
`else
  logic unused_signed;
  assign unused_signed = signed_i;
  assign sgn_in        = 1'b0;
`endif

  always_comb begin
    dvd_mag = (sgn_in && dividend_i[W-1]) ? -dividend_i : dividend_i;
    dvs_mag = (sgn_in && divisor_i[W-1])  ? -divisor_i  : divisor_i;
  end

  // Partial remainder kept one bit wider so divisors above 2^(W-1) still work;
  // the restore decision is the borrow out of the top subtractor stage.
  assign trial_a = {r_q, q_q[W-1]};
  assign trial_b = {1'b0, dvs_q};
  assign bw[0]   = 1'b0;

  for (genvar i = 0; i <= W; i++) begin : g_sub
    fullsubtractor u_fs (
      .a_i  (trial_a[i]),
      .b_i  (trial_b[i]),
      .bw_i (bw[i]),
      .d_o  (trial_d[i]),
      .bw_o (bw[i+1])
    );
  end

  assign borrow      = bw[W+1];
  assign unused_dmsb = trial_d[W];

  always_comb begin
    r_d = borrow ? trial_a[W-1:0] : trial_d[W-1:0];
    q_d = {q_q[W-2:0], ~borrow};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      q_q       <= '0;
      r_q       <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
`ifdef ALU_DIV_SIGNED_EN
      sgn_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            q_q    <= dvd_mag;
            r_q    <= '0;
            dvs_q  <= dvs_mag;
`ifdef ALU_DIV_SIGNED_EN
            sgn_q     <= signed_i;
            neg_quo_q <= signed_i & (dividend_i[W-1] ^ divisor_i[W-1]);
            neg_rem_q <= signed_i & dividend_i[W-1];
`endif
            if (divisor_i == '0) begin
              quo_q   <= '1;
              rem_q   <= dividend_i;
              dz_q    <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          q_q   <= q_d;
          r_q   <= r_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_STEP) begin
`ifdef ALU_DIV_SIGNED_EN
            if (sgn_q) begin
              state_q <= S_FIX;
            end else begin
              quo_q   <= q_d;
              rem_q   <= r_d;
              dz_q    <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
`else
            quo_q   <= q_d;
            rem_q   <= r_d;
            dz_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
`endif
          end
        end
`ifdef ALU_DIV_SIGNED_EN
        S_FIX: begin
          quo_q   <= neg_quo_q ? -q_q : q_q;
          rem_q   <= neg_rem_q ? -r_q : r_q;
          dz_q    <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
`endif
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
  assign dz_o        = dz_q;

endmodule
